// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MIPS mult/multu/div/divu unit with HI/LO and a stall request for colliding HI/LO accesses.
// Define MULDIV_FAST_MUL_EN to do multiplies in a single combinational step; divide always iterates.
module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              hilo_read,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic              flush,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opnd;
    logic                  r_is_div;
    logic                  r_neg_lo;
    logic                  r_neg_hi;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_done;

    logic                  w_signed;
    logic                  w_rs_neg;
    logic                  w_rt_neg;
    logic [DATA_W-1:0]     w_rs_abs;
    logic [DATA_W-1:0]     w_rt_abs;
    logic                  w_last;
    logic [DATA_W:0]       w_mul_sum;
    logic [2*DATA_W-1:0]   w_mul_next;
    logic [DATA_W:0]       w_div_trial;
    logic [2*DATA_W-1:0]   w_div_next;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_data[DATA_W-1];
    assign w_rt_neg = w_signed & rt_data[DATA_W-1];
    assign w_rs_abs = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_abs = w_rt_neg ? -rt_data : rt_data;
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

    // Shift-add: multiplier sits in the low half and drains out as the partial product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Restoring divide: remainder in the high half, dividend shifts out of the low half as quotient bits shift in.
    assign w_div_trial = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[DATA_W] ? {r_acc[2*DATA_W-2:0], 1'b0}
                                             : {w_div_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

    assign w_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_quot = r_neg_lo ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_hi ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] w_fast_prod;
    assign w_fast_prod = {{DATA_W{1'b0}}, w_rs_abs} * {{DATA_W{1'b0}}, w_rt_abs};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                        w_state_next = op[1] ? S_CALC : S_FIX;
`else
                        w_state_next = S_CALC;
`endif
                    end
                end
                S_CALC:  w_state_next = w_last ? S_FIX : S_CALC;
                S_FIX:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        stall_req = busy & (hilo_read | mthi | mtlo | start);
        hi        = r_hi;
        lo        = r_lo;
        done      = r_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_hi <= w_rs_neg;
                        // A zero divisor yields an all-ones quotient, which must not be negated.
                        r_neg_lo <= (w_rs_neg ^ w_rt_neg) & ~(op[1] & (rt_data == '0));
                        r_opnd   <= op[1] ? w_rt_abs : w_rs_abs;
`ifdef MULDIV_FAST_MUL_EN
                        r_acc    <= op[1] ? {{DATA_W{1'b0}}, w_rs_abs} : w_fast_prod;
`else
                        r_acc    <= {{DATA_W{1'b0}}, op[1] ? w_rs_abs : w_rt_abs};
`endif
                    end else if (!start && !flush) begin
                        if (mthi) r_hi <= rs_data;
                        if (mtlo) r_lo <= rs_data;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (!w_last) r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi   <= r_is_div ? w_rem  : w_prod[2*DATA_W-1:DATA_W];
                        r_lo   <= r_is_div ? w_quot : w_prod[DATA_W-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: results predicted at issue, compared when done pulses.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY  = 1;
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_BUSY  = 33;
    localparam int MUL_STALL = 32;
`endif
    localparam int DIV_BUSY = 33;

    logic        clk = 1'b0;
    logic        rst, start, hilo_read, mthi, mtlo, flush;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic [31:0] hi, lo;
    logic        busy, done, stall_req;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       tag;
        logic [63:0] res;
    } exp_t;
    exp_t sb[$];

    ex_muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hilo_read(hilo_read),
        .mthi(mthi), .mtlo(mtlo), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference result as {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (o)
            2'd0: begin p = sa * sb_; return p; end
            2'd1: return {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_hi"}, {32'b0, hi}, {32'b0, e.res[63:32]});
                check({e.tag, "_lo"}, {32'b0, lo}, {32'b0, e.res[31:0]});
            end
        end
    end

    // Called just after a posedge; returns just after E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int nb, output int nd);
        exp_t e;
        e.tag = tag;
        e.res = model(o, a, b);
        sb.push_back(e);
        issue(o, a, b);
        nb = 0; nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        @(posedge clk); #1;
        $display("op %s op=%0d rs=0x%08h rt=0x%08h busy=%0d done=%0d hi=0x%08h lo=0x%08h",
                 tag, o, a, b, nb, nd, hi, lo);
    endtask

    initial begin
        int nb, nd, ns;
        logic [63:0] m;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        hilo_read = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_stall", {63'b0, stall_req}, 64'd0);
        @(posedge clk); #1;

        run_op("mult", 2'd0, 32'd7, 32'hFFFF_FFFD, nb, nd);
        check("mult_busy_cyc", 64'(nb), 64'(MUL_BUSY));
        check("mult_done_cyc", 64'(nd), 64'd1);
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd);
        run_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2, nb, nd);
        check("div_busy_cyc", 64'(nb), 64'(DIV_BUSY));
        run_op("divu0", 2'd3, 32'd100, 32'd0, nb, nd);
        check("divu0_busy_cyc", 64'(nb), 64'(DIV_BUSY));
        run_op("div0neg", 2'd2, 32'hFFFF_FF00, 32'd0, nb, nd);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
        run_op("divneg", 2'd2, 32'd77, 32'hFFFF_FFF6, nb, nd);
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_op("rand", ro, ra, rb, nb, nd);
        end

        // mflo behind a mult: stalls while busy, then reads the new LO.
        m = model(2'd0, 32'h1234_5678, 32'hFFFF_0003);
        begin
            exp_t e;
            e.tag = "mflo_mult";
            e.res = m;
            sb.push_back(e);
        end
        issue(2'd0, 32'h1234_5678, 32'hFFFF_0003);
        @(posedge clk); #1 hilo_read = 1'b1;
        ns = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (stall_req) ns++;
        end
        $display("mflo stall_cycles=%0d lo=0x%08h", ns, lo);
        check("mflo_stall_cyc", 64'(ns), 64'(MUL_STALL));
        check("mflo_busy_fell", {63'b0, busy}, 64'd0);
        check("mflo_stall_off", {63'b0, stall_req}, 64'd0);
        check("mflo_lo", {32'b0, lo}, {32'b0, m[31:0]});
        @(posedge clk); #1 hilo_read = 1'b0;

        // mthi / mtlo while idle, then flush an in-flight divide.
        rs_data = 32'h11; mthi = 1'b1;
        @(negedge clk);
        check("mthi_stall", {63'b0, stall_req}, 64'd0);
        @(posedge clk); #1 mthi = 1'b0; rs_data = 32'h22; mtlo = 1'b1;
        @(posedge clk); #1 mtlo = 1'b0;
        @(negedge clk);
        check("mt_hi", {32'b0, hi}, 64'h11);
        check("mt_lo", {32'b0, lo}, 64'h22);
        @(posedge clk); #1;
        issue(2'd2, 32'd50, 32'd5);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        $display("flush busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_hi", {32'b0, hi}, 64'h11);
        check("flush_lo", {32'b0, lo}, 64'h22);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush_no_done", 64'(nd), 64'd0);

        // Reset mid-multu, then mthi while idle.
        @(posedge clk); #1;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        $display("midrst busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
        check("midrst_hi", {32'b0, hi}, 64'd0);
        check("midrst_lo", {32'b0, lo}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1 rs_data = 32'hABCD; mthi = 1'b1;
        @(negedge clk);
        check("mthi2_stall", {63'b0, stall_req}, 64'd0);
        @(posedge clk); #1 mthi = 1'b0;
        @(negedge clk);
        $display("mthi hi=0x%08h lo=0x%08h", hi, lo);
        check("mthi2_hi", {32'b0, hi}, 64'hABCD);
        check("mthi2_lo", {32'b0, lo}, 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
